// File: rtl/adc_capture_mc.sv
// Multi-channel ADC capture: shared divided ADC clock, per-window sample/max/min/mean
// reduction and a one-deep result register with overrun. Macro ADC_TEST_PATTERN_EN swaps in ramp data.
module adc_capture_mc #(
    parameter int NUM_CH        = 2,
    parameter int DATA_WIDTH    = 8,
    parameter int CLK_DIV_WIDTH = 32,
    parameter int MAX_WIN_LOG2  = 8
) (
    input  logic                         clk_i,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ADC_data,
    output logic                         ADC_oe,
    output logic                         clk_o,
    input  logic [CLK_DIV_WIDTH-1:0]     decimation_factor,
    input  logic [1:0]                   mode,
    input  logic [3:0]                   win_log2,
    output logic [NUM_CH*DATA_WIDTH-1:0] SI_data,
    output logic                         SI_rdy,
    input  logic                         SI_ack,
    output logic                         overrun,
    input  logic                         overrun_clr
);

    localparam int          ACC_W   = DATA_WIDTH + MAX_WIN_LOG2;
    localparam int          CNT_W   = MAX_WIN_LOG2;
    localparam logic [3:0]  MAX_WIN = 4'(MAX_WIN_LOG2);

    typedef enum logic [1:0] {
        MODE_SAMPLE = 2'd0,
        MODE_MAX    = 2'd1,
        MODE_MIN    = 2'd2,
        MODE_MEAN   = 2'd3
    } mode_e;

    logic [CLK_DIV_WIDTH-1:0] div_cnt;
    logic                     clk_div;
    logic                     d_zero;
    logic                     div_last;
    logic                     strobe;

    assign d_zero   = (decimation_factor == '0);
    assign div_last = (div_cnt == decimation_factor - CLK_DIV_WIDTH'(1));
    assign strobe   = d_zero || (div_last && !clk_div);
    assign clk_o    = d_zero ? clk_i : clk_div;
    assign ADC_oe   = 1'b0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst || d_zero) begin
            div_cnt <= '0;
            clk_div <= 1'b0;
        end else if (div_last) begin
            div_cnt <= '0;
            clk_div <= ~clk_div;
        end else begin
            div_cnt <= div_cnt + CLK_DIV_WIDTH'(1);
        end
    end

    logic [DATA_WIDTH-1:0] sample [NUM_CH];

`ifdef ADC_TEST_PATTERN_EN
    logic [DATA_WIDTH-1:0] ramp [NUM_CH];

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (rst)
                ramp[k] <= DATA_WIDTH'(k);
            else if (strobe)
                ramp[k] <= ramp[k] + DATA_WIDTH'(1);
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++)
            sample[k] = ramp[k];
    end
`else
    always_comb begin
        for (int k = 0; k < NUM_CH; k++)
            sample[k] = ADC_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
`endif

    logic [CNT_W-1:0]            win_cnt;
    logic [ACC_W-1:0]            acc      [NUM_CH];
    logic [ACC_W-1:0]            comb_acc [NUM_CH];
    mode_e                       mode_sh;
    logic [3:0]                  win_sh;
    logic [3:0]                  win_clamped;
    mode_e                       eff_mode;
    logic [3:0]                  eff_win;
    logic                        first;
    logic                        win_last;
    logic [CNT_W-1:0]            last_idx;
    logic [NUM_CH*DATA_WIDTH-1:0] result;
    logic [ACC_W-1:0]            ext;

    assign win_clamped = (win_log2 > MAX_WIN) ? MAX_WIN : win_log2;
    assign first       = (win_cnt == '0);
    // The first strobe of a window already runs under the configuration it latches.
    assign eff_mode    = first ? mode_e'(mode) : mode_sh;
    assign eff_win     = first ? win_clamped : win_sh;
    assign last_idx    = (eff_mode == MODE_SAMPLE) ? '0
                       : (CNT_W'(1) << eff_win) - CNT_W'(1);
    assign win_last    = (win_cnt == last_idx);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        result = '0;
        ext    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ext = ACC_W'(sample[k]);
            comb_acc[k] = ext;
            if (!first) begin
                unique case (eff_mode)
                    MODE_MAX:  comb_acc[k] = (ext > acc[k]) ? ext : acc[k];
                    MODE_MIN:  comb_acc[k] = (ext < acc[k]) ? ext : acc[k];
                    MODE_MEAN: comb_acc[k] = acc[k] + ext;
                    default:   comb_acc[k] = ext;
                endcase
            end
            if (eff_mode == MODE_MEAN)
                result[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(comb_acc[k] >> eff_win);
            else
                result[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(comb_acc[k]);
        end
    end

    // NOTE: the accumulator array is a handful of flops, not RAM, so it is reset like any register.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            win_cnt <= '0;
            mode_sh <= mode_e'(mode);
            win_sh  <= win_clamped;
            for (int k = 0; k < NUM_CH; k++)
                acc[k] <= '0;
        end else if (strobe) begin
            if (first) begin
                mode_sh <= eff_mode;
                win_sh  <= eff_win;
            end
            if (win_last) begin
                win_cnt <= '0;
            end else begin
                win_cnt <= win_cnt + CNT_W'(1);
                for (int k = 0; k < NUM_CH; k++)
                    acc[k] <= comb_acc[k];
            end
        end
    end

    logic done;
    logic load;

    assign done = strobe && win_last;
    assign load = done && (!SI_rdy || SI_ack);

    always_ff @(posedge clk_i) begin
        if (rst) begin
            SI_data <= '0;
            SI_rdy  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load) begin
                SI_data <= result;
                SI_rdy  <= 1'b1;
            end else if (SI_ack) begin
                SI_rdy  <= 1'b0;
            end
            if (done && !load)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_capture_mc.sv
// Self-checking bench for adc_capture_mc: vector table, hand-written corner sequences,
// and randomized traffic against a window-level reference model.
module tb_adc_capture_mc;

    localparam int NUM_CH = 2;
    localparam int DW     = 8;
    localparam int MAXW   = 8;

    logic                 clk_i = 1'b0;
    logic                 rst;
    logic [NUM_CH*DW-1:0] ADC_data;
    logic                 ADC_oe;
    logic                 clk_o;
    logic [31:0]          decimation_factor;
    logic [1:0]           mode;
    logic [3:0]           win_log2;
    logic [NUM_CH*DW-1:0] SI_data;
    logic                 SI_rdy;
    logic                 SI_ack;
    logic                 overrun;
    logic                 overrun_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    adc_capture_mc #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CLK_DIV_WIDTH(32), .MAX_WIN_LOG2(MAXW)) dut (
        .clk_i(clk_i), .rst(rst), .ADC_data(ADC_data), .ADC_oe(ADC_oe), .clk_o(clk_o),
        .decimation_factor(decimation_factor), .mode(mode), .win_log2(win_log2),
        .SI_data(SI_data), .SI_rdy(SI_rdy), .SI_ack(SI_ack),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Leaves the bench at a falling edge with rst low; the next rising edge is cycle 1.
    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic int reduce(input int md, input int w, input int s[$]);
        int r = s[0];
        for (int i = 1; i < s.size(); i++) begin
            case (md)
                1:       r = (s[i] > r) ? s[i] : r;
                2:       r = (s[i] < r) ? s[i] : r;
                3:       r = r + s[i];
                default: r = s[i];
            endcase
        end
        if (md == 3) r = r >> w;
        return r & 255;
    endfunction

    function automatic bit strobe_at(input int d, input int n);
        if (d == 0) return 1'b1;
        return (n >= d) && (((n - d) % (2 * d)) == 0);
    endfunction

    typedef struct packed {
        logic [1:0]  md;
        logic [3:0]  w;
        logic [31:0] s0;
        logic [31:0] s1;
        logic [7:0]  e0;
        logic [7:0]  e1;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vectors();
        logic [31:0] s0, s1;
        vecs[0] = '{2'd3, 4'd2, {8'd41, 8'd30, 8'd20, 8'd10}, {8'd4, 8'd3, 8'd2, 8'd1},     8'd25,  8'd2};
        vecs[1] = '{2'd1, 4'd2, {8'd9, 8'd7, 8'd200, 8'd5},   {8'd1, 8'd0, 8'd0, 8'd255},   8'd200, 8'd255};
        vecs[2] = '{2'd2, 4'd2, {8'd9, 8'd7, 8'd200, 8'd5},   {8'd7, 8'd250, 8'd8, 8'd9},   8'd5,   8'd7};
        vecs[3] = '{2'd0, 4'd2, {8'd9, 8'd7, 8'd200, 8'd5},   {8'd4, 8'd3, 8'd2, 8'd1},     8'd9,   8'd4};
        vecs[4] = '{2'd3, 4'd2, {8'd255, 8'd255, 8'd255, 8'd255}, {8'd3, 8'd0, 8'd0, 8'd0}, 8'd255, 8'd0};
        vecs[5] = '{2'd1, 4'd2, {8'd0, 8'd0, 8'd0, 8'd0},     {8'd128, 8'd127, 8'd129, 8'd1}, 8'd0, 8'd129};
        for (int v = 0; v < 6; v++) begin
            decimation_factor = 0;
            SI_ack      = 1'b1;
            overrun_clr = 1'b0;
            mode        = vecs[v].md;
            win_log2    = vecs[v].w;
            s0          = vecs[v].s0;
            s1          = vecs[v].s1;
            ADC_data    = '0;
            do_reset();
            for (int i = 0; i < 4; i++) begin
                ADC_data = {s1[i*8 +: 8], s0[i*8 +: 8]};
                step();
                if (i < 3 && vecs[v].md != 2'd0) check($sformatf("vec%0d_rdy_mid", v), SI_rdy, 0);
            end
            check($sformatf("vec%0d_rdy", v), SI_rdy, 1);
            check($sformatf("vec%0d_data", v), SI_data, {vecs[v].e1, vecs[v].e0});
        end
    endtask

    task automatic test_passthrough();
        decimation_factor = 0;
        mode = 2'd0; win_log2 = 4'd0;
        SI_ack = 1'b1; overrun_clr = 1'b0;
        ADC_data = 16'h3412;
        rst = 1'b1;
        step();
        check("rst_rdy", SI_rdy, 0);
        check("rst_data", SI_data, 0);
        check("rst_overrun", overrun, 0);
        check("rst_oe", ADC_oe, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("pass_rdy", SI_rdy, 1);
            check("pass_data", SI_data, 16'h3412);
        end
        check("clk_o_low", clk_o, 0);
        @(posedge clk_i);
        #1;
        check("clk_o_high", clk_o, 1);
        @(negedge clk_i);
        ADC_data = 16'hABCD;
        step();
        check("pass_reload_rdy", SI_rdy, 1);
        check("pass_reload_data", SI_data, 16'hABCD);
    endtask

    task automatic test_div3();
        int ns;
        decimation_factor = 3;
        mode = 2'd0; SI_ack = 1'b1; overrun_clr = 1'b0;
        ADC_data = '0;
        do_reset();
        for (int n = 1; n <= 18; n++) begin
            ADC_data = 16'(n * 37);
            step();
            check($sformatf("div3_clk_o_%0d", n), clk_o, (n / 3) % 2);
            check($sformatf("div3_rdy_%0d", n), SI_rdy, (n % 6) == 3);
            if (n >= 3) begin
                ns = n - ((n - 3) % 6);
                check($sformatf("div3_data_%0d", n), SI_data, 16'(ns * 37));
            end
        end
    endtask

    task automatic test_mode_change();
        decimation_factor = 0;
        SI_ack = 1'b1; overrun_clr = 1'b0;
        mode = 2'd1; win_log2 = 4'd2;
        ADC_data = '0;
        do_reset();
        ADC_data = 16'd5;   step();
        ADC_data = 16'd200; step();
        mode = 2'd2;
        ADC_data = 16'd7;   step();
        ADC_data = 16'd9;   step();
        check("modechg_old_window", SI_data, 16'd200);
        ADC_data = 16'd5;   step();
        ADC_data = 16'd200; step();
        ADC_data = 16'd7;   step();
        ADC_data = 16'd9;   step();
        check("modechg_new_rdy", SI_rdy, 1);
        check("modechg_new_window", SI_data, 16'd5);
    endtask

    task automatic test_overrun();
        decimation_factor = 1;
        mode = 2'd0; win_log2 = 4'd0;
        SI_ack = 1'b0; overrun_clr = 1'b0;
        ADC_data = 16'h1111;
        do_reset();
        step();
        check("ovr_first_rdy", SI_rdy, 1);
        check("ovr_first_data", SI_data, 16'h1111);
        check("ovr_first_flag", overrun, 0);
        ADC_data = 16'h2222;
        step();
        step();
        check("ovr_held_data", SI_data, 16'h1111);
        check("ovr_set", overrun, 1);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        check("ovr_cleared", overrun, 0);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        check("ovr_set_beats_clr", overrun, 1);
        SI_ack = 1'b1; step(); SI_ack = 1'b0;
        check("ovr_ack_drops_rdy", SI_rdy, 0);
        step();
        check("ovr_reload_rdy", SI_rdy, 1);
        check("ovr_reload_data", SI_data, 16'h2222);
    endtask

    task automatic test_clamp();
        int mx0, mx1;
        logic [7:0] b0, b1;
        decimation_factor = 0;
        mode = 2'd1; win_log2 = 4'd12;
        SI_ack = 1'b1; overrun_clr = 1'b0;
        ADC_data = '0;
        mx0 = 0; mx1 = 0;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            if (b0 > mx0) mx0 = b0;
            if (b1 > mx1) mx1 = b1;
            ADC_data = {b1, b0};
            step();
            if (i == 254) check("clamp_rdy_early", SI_rdy, 0);
        end
        check("clamp_rdy", SI_rdy, 1);
        check("clamp_data", SI_data, {8'(mx1), 8'(mx0)});
    endtask

    task automatic run_random(input int d, input int cycles);
        int q0[$], q1[$];
        int cm, cw, len;
        bit done, load, m_rdy, m_over;
        logic [15:0] m_data, res;
        decimation_factor = d;
        mode = 2'($urandom_range(0, 3));
        win_log2 = 4'($urandom_range(0, 3));
        SI_ack = 1'b1; overrun_clr = 1'b0;
        ADC_data = '0;
        do_reset();
        m_rdy = 0; m_over = 0; m_data = '0;
        cm = 0; cw = 0; res = '0;
        for (int n = 1; n <= cycles; n++) begin
            ADC_data    = 16'($urandom);
            SI_ack      = ($urandom_range(0, 3) != 0);
            overrun_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) win_log2 = 4'($urandom_range(0, 3));
            done = 0;
            if (strobe_at(d, n)) begin
                if (q0.size() == 0) begin
                    cm = mode;
                    cw = (win_log2 > MAXW) ? MAXW : win_log2;
                end
                q0.push_back(ADC_data[7:0]);
                q1.push_back(ADC_data[15:8]);
                len = (cm == 0) ? 1 : (1 << cw);
                if (q0.size() == len) begin
                    done = 1;
                    res  = {8'(reduce(cm, cw, q1)), 8'(reduce(cm, cw, q0))};
                    q0.delete();
                    q1.delete();
                end
            end
            load = done && (!m_rdy || SI_ack);
            if (load) begin
                m_data = res;
                m_rdy  = 1;
            end else if (m_rdy && SI_ack) begin
                m_rdy = 0;
            end
            if (done && !load) m_over = 1;
            else if (overrun_clr) m_over = 0;
            step();
            check($sformatf("rnd_d%0d_rdy_%0d", d, n), SI_rdy, m_rdy);
            check($sformatf("rnd_d%0d_data_%0d", d, n), SI_data, m_data);
            check($sformatf("rnd_d%0d_ovr_%0d", d, n), overrun, m_over);
        end
        overrun_clr = 1'b0;
    endtask

`ifdef ADC_TEST_PATTERN_EN
    task automatic test_ramp();
        decimation_factor = 0;
        mode = 2'd0; win_log2 = 4'd0;
        SI_ack = 1'b1; overrun_clr = 1'b0;
        ADC_data = '0;
        do_reset();
        for (int n = 1; n <= 6; n++) begin
            step();
            check($sformatf("ramp_%0d", n), SI_data, {8'(n), 8'(n - 1)});
        end
        rst = 1'b1; step(); rst = 1'b0;
        check("ramp_rst_rdy", SI_rdy, 0);
        for (int n = 1; n <= 4; n++) begin
            step();
            check($sformatf("ramp_after_rst_%0d", n), SI_data, {8'(n), 8'(n - 1)});
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        ADC_data = '0;
        decimation_factor = 0;
        mode = 2'd0;
        win_log2 = 4'd0;
        SI_ack = 1'b0;
        overrun_clr = 1'b0;
        @(negedge clk_i);
`ifdef ADC_TEST_PATTERN_EN
        test_ramp();
`else
        test_passthrough();
        test_div3();
        run_vectors();
        test_mode_change();
        test_overrun();
        test_clamp();
        for (int d = 0; d < 4; d++) run_random(d, 300);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
